phase_ctrl: RTL and testbench
=============================

Name: phase_ctrl

Overview:
- Single-clock stage sequencer for the cpu15 datapath; replaces free-running phase clocks with one-hot stage enables (fetch/decode/exec/writeback).
- Adds run/stop/single-step control, HLT-instruction halt, external halt request and a retired-instruction counter.
- Sits between the top-level control inputs and the fetch/decode/exec/writeback stage blocks.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- EX_WAIT, 0, extra exec-phase cycles (0..7) before EN_EX fires; allows RAM/IO settling.
- HLT_OP, 4'hF, opcode value treated as HLT.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- RUN  in  1  level; 1 = free-run instructions.
- STEP  in  1  one-cycle pulse; execute exactly one instruction from IDLE.
- HALT_REQ  in  1  pulse; stop after the current instruction retires.
- OP_CODE  in  4  decoded opcode from decode stage.
- P_COUNT  in  8  current program counter.
- EN_FT  out  1  fetch enable.
- EN_DC  out  1  decode enable.
- EN_EX  out  1  exec enable.
- EN_WB  out  1  writeback enable.
- STATE  out  3  current FSM state encoding.
- STOPPED  out  1  high in IDLE or HALT.
- HALTED  out  1  high in HALT only.
- INSTR_CNT  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous, active-high.
- Reset values: STATE=IDLE, all EN_*=0, STOPPED=1, HALTED=0, INSTR_CNT=0, halt-pending=0, step-flag=0, wait counter=0. Reset mid-instruction aborts it the same way.
- All outputs are registered. EN_* are one-hot or all-zero and each is high for exactly one cycle per instruction.
- States: IDLE, FT, DC, EX, WB, HALT.
- IDLE:
  - RUN=1 -> FT.
  - Else STEP=1 -> FT and set step-flag.
  - RUN and STEP together: RUN wins and STEP is dropped.
- FT -> DC -> EX. EN_FT is asserted in FT, EN_DC in DC.
- DC: latch OP_CODE into an internal op register.
- EX:
  - Stays 1+EX_WAIT cycles.
  - EN_EX is high only on the final EX cycle; the wait counter clears on exit.
- WB: EN_WB=1 and INSTR_CNT increments (wraps at 2^CNT_W). Next state by priority:
  - latched op==HLT_OP -> HALT.
  - halt-pending, step-flag, or RUN=0 -> IDLE; clears halt-pending and step-flag.
  - Otherwise -> FT.
- HALT: sticky; exits only on RESET. RUN, STEP and HALT_REQ are ignored.
- HALT_REQ:
  - Sampled in any state except IDLE/HALT; sets halt-pending, which is consumed at WB.
  - Ignored in IDLE and HALT.
- STEP outside IDLE is ignored. RUN deasserted mid-instruction does not abort; the current instruction completes.
- Latency:
  - RUN or STEP sampled high in IDLE at edge n -> EN_FT high in cycle n+1.
  - One instruction = 4+EX_WAIT cycles; back-to-back free-run has no idle gap.
- P_COUNT is used only by the optional feature.

Optional Feature:
- Macro: PHASE_CTRL_BREAKPOINT_EN.
- Defined: adds ports BP_VALID in 1, BP_ADDR in 8, BP_HIT out 1.
  - At WB, if BP_VALID and P_COUNT==BP_ADDR, go to IDLE instead of FT and set BP_HIT=1.
  - BP_HIT stays set until IDLE is next left; reset value 0.
  - The first WB after leaving IDLE ignores the compare, so resuming does not re-trigger.
  - HLT priority is above the breakpoint; the breakpoint is above halt-pending/RUN.
- Undefined: no ports, no compare logic; behaviour as above.

Decomposition:
- Shared package cpu15_pkg:
  - state encodings: IDLE=0, FT=1, DC=2, EX=3, WB=4, HALT=5;
  - HLT opcode constant;
  - opcode width 4 and PC width 8.
- No sub-module; FSM, wait counter and instruction counter live in one module.

Test Plan:
- RESET=1 two cycles, then RUN=1 with EX_WAIT=0 and non-HLT ops -> EN_FT/DC/EX/WB one-hot in consecutive cycles repeating every 4 cycles; INSTR_CNT=3 after 12 cycles.
- Single-step: RUN=0, pulse STEP in IDLE -> exactly one FT..WB sequence, STATE back to IDLE, INSTR_CNT=1; a second STEP pulsed during EX is ignored.
- HLT: OP_CODE=4'hF at DC -> WB asserted, then STATE=HALT, HALTED=1; RUN and STEP have no effect; RESET returns to IDLE with INSTR_CNT=0.
- HALT_REQ pulsed in DC while RUN=1 -> instruction retires, STATE=IDLE, STOPPED=1; RUN still high -> FT starts the next cycle.
- EX_WAIT=3 -> FT, DC, four EX cycles with EN_EX only on the fourth, then WB (7 cycles per instruction); RESET during EX -> all EN_*=0 next cycle.
- With PHASE_CTRL_BREAKPOINT_EN: BP_ADDR=8'h05, BP_VALID=1 -> stops in IDLE with BP_HIT=1 when P_COUNT=5 at WB; RUN resumes without immediate re-hit.

Source files
------------

// File: rtl/cpu15_pkg.sv
// Shared definitions for the cpu15 control path.
//   - state_t    : stage-sequencer state encoding (also driven out on STATE)
//   - OP_W/PC_W  : opcode and program-counter widths
//   - HLT_OPCODE : opcode that parks the sequencer in HALT
package cpu15_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned PC_W = 8;

  localparam logic [OP_W-1:0] HLT_OPCODE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FT   = 3'd1,
    ST_DC   = 3'd2,
    ST_EX   = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // IDLE and HALT are the two states in which no instruction is in flight.
  function automatic logic is_stopped(input state_t s);
    return (s == ST_IDLE) || (s == ST_HALT);
  endfunction

endpackage

// File: rtl/phase_ctrl.sv
// phase_ctrl: single-clock stage sequencer for the cpu15 datapath.
// Produces one-hot fetch/decode/exec/writeback enables, with run/stop,
// single-step, HLT halt, external halt request and a retired-instruction
// counter.
//
// Ports:
//   CLK, RESET       clock, synchronous active-high reset
//   RUN              level, free-run instructions while high
//   STEP             pulse, run exactly one instruction from IDLE
//   HALT_REQ         pulse, stop after the current instruction retires
//   OP_CODE[3:0]     opcode from decode stage, latched in DC
//   P_COUNT[7:0]     program counter (breakpoint compare only)
//   EN_FT/DC/EX/WB   registered stage enables, one-hot or all-zero
//   STATE[2:0]       current state encoding
//   STOPPED, HALTED  status flags
//   INSTR_CNT        retired-instruction count (wraps)
//
// Optional build macro PHASE_CTRL_BREAKPOINT_EN adds:
//   BP_VALID, BP_ADDR[7:0] (in), BP_HIT (out) -- stop in IDLE at a
//   writeback whose P_COUNT equals BP_ADDR.
module phase_ctrl
  import cpu15_pkg::*;
#(
  parameter int unsigned     CNT_W   = 16,
  parameter int unsigned     EX_WAIT = 0,
  parameter logic [OP_W-1:0] HLT_OP  = HLT_OPCODE
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             HALT_REQ,
  input  logic [OP_W-1:0]  OP_CODE,
  input  logic [PC_W-1:0]  P_COUNT,
`ifdef PHASE_CTRL_BREAKPOINT_EN
  input  logic             BP_VALID,
  input  logic [PC_W-1:0]  BP_ADDR,
  output logic             BP_HIT,
`endif
  output logic             EN_FT,
  output logic             EN_DC,
  output logic             EN_EX,
  output logic             EN_WB,
  output logic [2:0]       STATE,
  output logic             STOPPED,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [2:0] EX_LAST = 3'(EX_WAIT);

  state_t            state, state_nx;
  logic [2:0]        wait_cnt, wait_nx;
  logic              halt_pend, pend_nx;
  logic              step_flag, step_nx;
  logic [OP_W-1:0]   op_reg, op_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              bp_match;

`ifdef PHASE_CTRL_BREAKPOINT_EN
  logic              bp_skip, bp_skip_nx;
  logic              bp_hit_nx;

  // The first writeback after leaving IDLE is exempt so a resume from a
  // breakpoint does not immediately stop on the same address.
  assign bp_match = ~bp_skip & BP_VALID & (P_COUNT == BP_ADDR);
`else
  logic              unused_pc;

  assign bp_match  = 1'b0;
  assign unused_pc = ^P_COUNT;
`endif

  assign STATE = state;

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    pend_nx  = halt_pend;
    step_nx  = step_flag;
    op_nx    = op_reg;
    cnt_nx   = INSTR_CNT;
`ifdef PHASE_CTRL_BREAKPOINT_EN
    bp_skip_nx = bp_skip;
    bp_hit_nx  = BP_HIT;
`endif

    case (state)
      ST_IDLE: begin
        if (RUN || STEP) begin
          state_nx = ST_FT;
          step_nx  = ~RUN & STEP;
`ifdef PHASE_CTRL_BREAKPOINT_EN
          bp_skip_nx = 1'b1;
          bp_hit_nx  = 1'b0;
`endif
        end
      end

      ST_FT: begin
        state_nx = ST_DC;
        if (HALT_REQ) pend_nx = 1'b1;
      end

      ST_DC: begin
        state_nx = ST_EX;
        op_nx    = OP_CODE;
        wait_nx  = '0;
        if (HALT_REQ) pend_nx = 1'b1;
      end

      ST_EX: begin
        if (HALT_REQ) pend_nx = 1'b1;
        if (wait_cnt == EX_LAST) begin
          state_nx = ST_WB;
          wait_nx  = '0;
        end else begin
          wait_nx  = wait_cnt + 3'd1;
        end
      end

      ST_WB: begin
        cnt_nx = INSTR_CNT + CNT_W'(1);
`ifdef PHASE_CTRL_BREAKPOINT_EN
        bp_skip_nx = 1'b0;
`endif
        // A request arriving in the writeback cycle itself still stops
        // at this retirement.
        if (op_reg == HLT_OP) begin
          state_nx = ST_HALT;
          pend_nx  = 1'b0;
          step_nx  = 1'b0;
        end else if (bp_match) begin
          state_nx = ST_IDLE;
          pend_nx  = 1'b0;
          step_nx  = 1'b0;
`ifdef PHASE_CTRL_BREAKPOINT_EN
          bp_hit_nx = 1'b1;
`endif
        end else if (halt_pend || HALT_REQ || step_flag || !RUN) begin
          state_nx = ST_IDLE;
          pend_nx  = 1'b0;
          step_nx  = 1'b0;
        end else begin
          state_nx = ST_FT;
        end
      end

      ST_HALT: state_nx = ST_HALT;

      default: state_nx = ST_IDLE;
    endcase
  end

  // Enables and status are registered off the next-state values so they
  // line up with STATE in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      halt_pend <= 1'b0;
      step_flag <= 1'b0;
      op_reg    <= '0;
      INSTR_CNT <= '0;
      EN_FT     <= 1'b0;
      EN_DC     <= 1'b0;
      EN_EX     <= 1'b0;
      EN_WB     <= 1'b0;
      STOPPED   <= 1'b1;
      HALTED    <= 1'b0;
`ifdef PHASE_CTRL_BREAKPOINT_EN
      bp_skip   <= 1'b0;
      BP_HIT    <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      halt_pend <= pend_nx;
      step_flag <= step_nx;
      op_reg    <= op_nx;
      INSTR_CNT <= cnt_nx;
      EN_FT     <= (state_nx == ST_FT);
      EN_DC     <= (state_nx == ST_DC);
      EN_EX     <= (state_nx == ST_EX) && (wait_nx == EX_LAST);
      EN_WB     <= (state_nx == ST_WB);
      STOPPED   <= is_stopped(state_nx);
      HALTED    <= (state_nx == ST_HALT);
`ifdef PHASE_CTRL_BREAKPOINT_EN
      bp_skip   <= bp_skip_nx;
      BP_HIT    <= bp_hit_nx;
`endif
    end
  end

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl: two instances (EX_WAIT=0 and EX_WAIT=3)
// share stimulus; a position-within-instruction model predicts every output
// each cycle, and literal expectations pin key points of the sequence.
module tb_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, step, hreq;
  logic [3:0] op;
  logic [7:0] pc;
  logic       bp_valid;
  logic [7:0] bp_addr;

  logic        en_ft [2];
  logic        en_dc [2];
  logic        en_ex [2];
  logic        en_wb [2];
  logic [2:0]  st    [2];
  logic        stp   [2];
  logic        hlt   [2];
  logic [15:0] cnt   [2];
  logic        bph   [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  phase_ctrl #(.CNT_W(16), .EX_WAIT(0), .HLT_OP(4'hF)) dut0 (
    .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .HALT_REQ(hreq),
    .OP_CODE(op), .P_COUNT(pc),
`ifdef PHASE_CTRL_BREAKPOINT_EN
    .BP_VALID(bp_valid), .BP_ADDR(bp_addr), .BP_HIT(bph[0]),
`endif
    .EN_FT(en_ft[0]), .EN_DC(en_dc[0]), .EN_EX(en_ex[0]), .EN_WB(en_wb[0]),
    .STATE(st[0]), .STOPPED(stp[0]), .HALTED(hlt[0]), .INSTR_CNT(cnt[0])
  );

  phase_ctrl #(.CNT_W(16), .EX_WAIT(3), .HLT_OP(4'hF)) dut1 (
    .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .HALT_REQ(hreq),
    .OP_CODE(op), .P_COUNT(pc),
`ifdef PHASE_CTRL_BREAKPOINT_EN
    .BP_VALID(bp_valid), .BP_ADDR(bp_addr), .BP_HIT(bph[1]),
`endif
    .EN_FT(en_ft[1]), .EN_DC(en_dc[1]), .EN_EX(en_ex[1]), .EN_WB(en_wb[1]),
    .STATE(st[1]), .STOPPED(stp[1]), .HALTED(hlt[1]), .INSTR_CNT(cnt[1])
  );

`ifndef PHASE_CTRL_BREAKPOINT_EN
  assign bph[0] = 1'b0;
  assign bph[1] = 1'b0;
`endif

  // Model: an instruction is a sequence of L = 4+EX_WAIT cycles indexed by
  // pos (0 = fetch, 1 = decode, L-2 = exec fire, L-1 = writeback).
  int          m_len [2] = '{4, 7};
  bit          m_busy[2];
  bit          m_halt[2];
  int          m_pos [2];
  int unsigned m_cnt [2];
  bit          m_pend[2];
  bit          m_step[2];
  logic [3:0]  m_op  [2];
  bit          m_skip[2];
  bit          m_bph [2];

  task automatic model_step(input int k);
    if (rst) begin
      m_busy[k] = 0; m_halt[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
      m_pend[k] = 0; m_step[k] = 0; m_op[k] = '0; m_skip[k] = 0; m_bph[k] = 0;
    end else if (m_halt[k]) begin
      // sticky
    end else if (!m_busy[k]) begin
      if (run || step) begin
        m_busy[k] = 1; m_pos[k] = 0; m_step[k] = !run;
        m_skip[k] = 1; m_bph[k] = 0;
      end
    end else begin
      bit last, hit;
      last = (m_pos[k] == m_len[k] - 1);
      if (!last && hreq) m_pend[k] = 1;
      if (m_pos[k] == 1) m_op[k] = op;
      if (!last) begin
        m_pos[k]++;
      end else begin
        m_cnt[k] = (m_cnt[k] + 1) % 65536;
`ifdef PHASE_CTRL_BREAKPOINT_EN
        hit = !m_skip[k] && bp_valid && (pc == bp_addr);
`else
        hit = 0;
`endif
        m_skip[k] = 0;
        if (m_op[k] == 4'hF) begin
          m_halt[k] = 1; m_busy[k] = 0;
        end else if (hit || m_pend[k] || hreq || m_step[k] || !run) begin
          m_busy[k] = 0; m_pend[k] = 0; m_step[k] = 0;
          if (hit) m_bph[k] = 1;
        end else begin
          m_pos[k] = 0;
        end
      end
    end
  endtask

  function automatic int exp_state(input int k);
    if (m_halt[k]) return 5;
    if (!m_busy[k]) return 0;
    if (m_pos[k] == 0) return 1;
    if (m_pos[k] == 1) return 2;
    if (m_pos[k] < m_len[k] - 1) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] exp_en(input int k);
    if (!m_busy[k]) return 4'b0000;
    return {m_pos[k] == 0, m_pos[k] == 1, m_pos[k] == m_len[k] - 2,
            m_pos[k] == m_len[k] - 1};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d_en", k), {28'd0, en_ft[k], en_dc[k], en_ex[k], en_wb[k]},
            {28'd0, exp_en(k)});
        chk($sformatf("d%0d_state", k), {29'd0, st[k]}, exp_state(k));
        chk($sformatf("d%0d_stopped", k), {31'd0, stp[k]}, {31'd0, !m_busy[k]});
        chk($sformatf("d%0d_halted", k), {31'd0, hlt[k]}, {31'd0, m_halt[k]});
        chk($sformatf("d%0d_cnt", k), {16'd0, cnt[k]}, m_cnt[k]);
`ifdef PHASE_CTRL_BREAKPOINT_EN
        chk($sformatf("d%0d_bphit", k), {31'd0, bph[k]}, {31'd0, m_bph[k]});
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; run = 0; step = 0; hreq = 0; op = 4'h1; pc = 8'h00;
    bp_valid = 0; bp_addr = 8'h00;

    // reset
    tick(2);
    chk_en = 1;
    chk("rst_state", {29'd0, st[0]}, 32'd0);
    chk("rst_stopped", {31'd0, stp[0]}, 32'd1);
    chk("rst_en", {28'd0, en_ft[0], en_dc[0], en_ex[0], en_wb[0]}, 32'd0);
    chk("rst_cnt", {16'd0, cnt[0]}, 32'd0);

    // free run
    rst = 0; run = 1;
    tick(1);
    chk("run_ft0", {31'd0, en_ft[0]}, 32'd1);
    chk("run_st1", {29'd0, st[1]}, 32'd1);
    tick(12);
    chk("run_cnt0", {16'd0, cnt[0]}, 32'd3);
    chk("run_cnt1", {16'd0, cnt[1]}, 32'd1);
    run = 0;
    tick(10);
    chk("stop_st0", {29'd0, st[0]}, 32'd0);
    chk("stop_st1", {29'd0, st[1]}, 32'd0);

    // single step, second STEP during EX ignored
    rst = 1; tick(1); rst = 0;
    step = 1; tick(1); step = 0;
    tick(2);
    step = 1; tick(1); step = 0;
    tick(6);
    chk("step_st0", {29'd0, st[0]}, 32'd0);
    chk("step_cnt0", {16'd0, cnt[0]}, 32'd1);
    chk("step_cnt1", {16'd0, cnt[1]}, 32'd1);

    // halt request during DC with RUN held
    rst = 1; tick(1); rst = 0;
    run = 1; tick(2);
    hreq = 1; tick(1); hreq = 0;
    tick(2);
    chk("hreq_st0", {29'd0, st[0]}, 32'd0);
    chk("hreq_stp0", {31'd0, stp[0]}, 32'd1);
    chk("hreq_cnt0", {16'd0, cnt[0]}, 32'd1);
    tick(1);
    chk("hreq_ft0", {31'd0, en_ft[0]}, 32'd1);
    run = 0; tick(10);

    // HLT opcode
    rst = 1; tick(1); rst = 0;
    op = 4'hF; run = 1;
    tick(5);
    chk("hlt_st0", {29'd0, st[0]}, 32'd5);
    chk("hlt_h0", {31'd0, hlt[0]}, 32'd1);
    chk("hlt_cnt0", {16'd0, cnt[0]}, 32'd1);
    step = 1; hreq = 1; tick(1); step = 0; hreq = 0;
    run = 0; tick(2); run = 1; tick(8);
    chk("hlt_sticky0", {29'd0, st[0]}, 32'd5);
    chk("hlt_sticky1", {29'd0, st[1]}, 32'd5);
    rst = 1; tick(1);
    chk("hlt_rst_st", {29'd0, st[1]}, 32'd0);
    chk("hlt_rst_cnt", {16'd0, cnt[1]}, 32'd0);
    chk("hlt_rst_h", {31'd0, hlt[1]}, 32'd0);
    rst = 0; run = 0; op = 4'h2;

    // EX_WAIT=3 timing, then reset mid-EX
    run = 1;
    tick(3);
    chk("w3_ex_early", {31'd0, en_ex[1]}, 32'd0);
    chk("w3_ex_st", {29'd0, st[1]}, 32'd3);
    tick(3);
    chk("w3_ex_fire", {31'd0, en_ex[1]}, 32'd1);
    tick(1);
    chk("w3_wb", {31'd0, en_wb[1]}, 32'd1);
    tick(4);
    chk("w3_ex2_st", {29'd0, st[1]}, 32'd3);
    rst = 1; tick(1);
    chk("w3_rst_en", {28'd0, en_ft[1], en_dc[1], en_ex[1], en_wb[1]}, 32'd0);
    rst = 0; run = 0; tick(2);

`ifdef PHASE_CTRL_BREAKPOINT_EN
    rst = 1; tick(1); rst = 0;
    bp_addr = 8'h05; bp_valid = 1; pc = 8'h05; run = 1;
    tick(4);
    chk("bp_skip_wb", {29'd0, st[0]}, 32'd4);
    tick(5);
    chk("bp_hit_st", {29'd0, st[0]}, 32'd0);
    chk("bp_hit", {31'd0, bph[0]}, 32'd1);
    tick(1);
    chk("bp_resume", {31'd0, en_ft[0]}, 32'd1);
    chk("bp_clr", {31'd0, bph[0]}, 32'd0);
    tick(4);
    chk("bp_no_rehit", {29'd0, st[0]}, 32'd1);
    run = 0; bp_valid = 0; tick(10);
`endif

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
